// File: rtl/biu_pkg.sv
// Shared definitions for the master- and slave-side bus interface units.
package biu_pkg;

  localparam int unsigned BUS_RNW_BIT        = 1;
  localparam int unsigned BUS_DATA_VALID_BIT = 0;

  typedef enum logic [3:0] {
    IDLE     = 4'b0001,
    ARB      = 4'b0010,
    SEND_REQ = 4'b0100,
    WAIT_RSP = 4'b1000
  } biu_master_state_t;

endpackage

// File: rtl/bus_if.sv
// Shared tri-state bus. Each agent supplies a value and an output enable; the
// resolved address/data/control nets float to 'z when no agent drives them.
interface bus_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  m_oe;
  logic [ADDR_WIDTH-1:0] m_address;
  logic [DATA_WIDTH-1:0] m_data;
  logic [1:0]            m_control;

  logic                  s_oe;
  logic [ADDR_WIDTH-1:0] s_address;
  logic [DATA_WIDTH-1:0] s_data;
  logic [1:0]            s_control;

  wire  [ADDR_WIDTH-1:0] address;
  wire  [DATA_WIDTH-1:0] data;
  wire  [1:0]            control;

  assign address = m_oe ? m_address : 'z;
  assign data    = m_oe ? m_data    : 'z;
  assign control = m_oe ? m_control : 'z;

  assign address = s_oe ? s_address : 'z;
  assign data    = s_oe ? s_data    : 'z;
  assign control = s_oe ? s_control : 'z;

  modport master (
    output m_oe, m_address, m_data, m_control,
    input  address, data, control
  );

  modport slave (
    output s_oe, s_address, s_data, s_control,
    input  address, data, control
  );

endinterface

// File: rtl/biu_timeout_counter.sv
// Saturating wait counter: cleared explicitly, counts while enabled, and flags
// expiry once it has reached TIMEOUT-1.
module biu_timeout_counter #(
  parameter int unsigned TIMEOUT       = 16,
  parameter int unsigned TIMEOUT_WIDTH = $clog2(TIMEOUT) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TIMEOUT_WIDTH-1:0] count_q, count_d;

  assign expired = (count_q == TIMEOUT_WIDTH'(TIMEOUT - 1));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + TIMEOUT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/biu_master.sv
// Master-side bus interface unit: arbitrates for the shared bus, issues one
// request beat, and for reads waits for the matching response or a timeout.
module biu_master
  import biu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned TIMEOUT       = 16,
  parameter int unsigned TIMEOUT_WIDTH = $clog2(TIMEOUT) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  bus_if.master                 bus,
  output logic                  bus_req,
  input  logic                  bus_gnt,
  input  logic                  i_en,
  input  logic                  i_rnw,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_error
);

  biu_master_state_t state_q, state_d;

  logic                  rnw_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic                  accept;
  logic                  rsp_hit;
  logic                  cnt_clear;
  logic                  cnt_en;
  logic                  cnt_expired;
  logic [1:0]            ctrl;

  biu_timeout_counter #(
    .TIMEOUT       (TIMEOUT),
    .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (cnt_clear),
    .enable  (cnt_en),
    .expired (cnt_expired)
  );

  assign accept  = (state_q == IDLE) && i_en;
  assign o_ready = (state_q == IDLE);
  assign bus_req = (state_q != IDLE);
  assign o_done  = done_q;
  assign o_error = error_q;
  assign o_data  = rdata_q;

  // A response is a read-flagged valid beat echoing our own full address.
  assign rsp_hit = bus.control[BUS_DATA_VALID_BIT] && bus.control[BUS_RNW_BIT] &&
                   (bus.address == addr_q);

  always_comb begin
    ctrl                     = '0;
    ctrl[BUS_RNW_BIT]        = rnw_q;
    ctrl[BUS_DATA_VALID_BIT] = 1'b1;
  end

  assign bus.m_oe      = (state_q == SEND_REQ);
  assign bus.m_address = addr_q;
  assign bus.m_data    = data_q;
  assign bus.m_control = ctrl;

  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_en) begin
          state_d = ARB;
        end
      end
      ARB: begin
        if (bus_gnt) begin
          state_d = SEND_REQ;
        end
      end
      SEND_REQ: begin
        if (rnw_q) begin
          cnt_clear = 1'b1;
          state_d   = WAIT_RSP;
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT_RSP: begin
        // A response in the expiry cycle still counts as a success.
        if (rsp_hit) begin
          rdata_d = bus.data;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (cnt_expired) begin
          done_d  = 1'b1;
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rnw_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      error_q <= error_d;
      if (accept) begin
        rnw_q  <= i_rnw;
        addr_q <= i_address;
        data_q <= i_data;
      end
    end
  end

endmodule
